alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester round-robin arbiter and sequencer for the single 16-bit ALU (`ALU1` / `minimal_ALU`, 3-bit opcode, carry-in, zero/negative flags). It accepts one operation at a time from either requester and drives registered operands into the external combinational ALU. It captures the result and flags one cycle later and returns them to the winning requester with a done pulse. The ALU is instantiated beside this block; this block only sequences and shares it.

## Interface
- No parameters; data width is fixed at 16, opcode width at 3.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `r0_req`, `r1_req` in 1: operation request from requester 0 or 1.
- `r0_opc`, `r1_opc` in 3: ALU opcode; sampled on grant.
- `r0_a`, `r1_a` in 16: operand A; sampled on grant.
- `r0_b`, `r1_b` in 16: operand B; sampled on grant.
- `r0_c`, `r1_c` in 1: carry-in; sampled on grant.
- `r0_ack`, `r1_ack` out 1: one-cycle pulse, request accepted.
- `r0_done`, `r1_done` out 1: one-cycle pulse, result valid.
- `r0_res`, `r1_res` out 16: captured `outW`; held until the next done for the same requester.
- `r0_zer`, `r0_neg`, `r1_zer`, `r1_neg` out 1: captured flags; held like `res`.
- `alu_inA`, `alu_inB` out 16, `alu_opc` out 3, `alu_inC` out 1: registered drive to the ALU.
- `alu_outW` in 16, `alu_zer` in 1, `alu_neg` in 1: ALU outputs.
- `busy` out 1: high while state is not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate any request.
  - EXEC: operands are on the ALU.
  - RESP: result is returned.
- Transitions: IDLE→EXEC on any req; EXEC→RESP always; RESP→IDLE always.
- Arbitration happens in IDLE only.
  - Single request: grant it.
  - Both requesting: grant the requester ≠ `last_grant`.
  - `last_grant` updates on every grant.
- On grant, latch the winner's opc/a/b/c into the `alu_*` registers and record the granted id.
- In EXEC, capture `alu_outW`, `alu_zer`, `alu_neg` into the granted requester's result registers.
- The non-granted requester's result registers are untouched.
- `alu_*` registers hold their last values between operations; they are not cleared after use.
- Requests are level-sensitive, with no queueing.
  - A requester must drop `req` in its ack cycle. Otherwise, if `req` is still high when the FSM next reaches IDLE, a new operation is issued.
  - `req` in EXEC/RESP is ignored but not lost: it waits, and the requester holds its operands stable until ack.
- Starvation-free: with both requesters held high, grants alternate 0,1,0,1…

## Timing
- Reset values:
  - state IDLE, `last_grant`=1 (requester 0 wins the first tie).
  - All ack/done/busy = 0.
  - All res = 0, all flags = 0.
  - `alu_inA`/`alu_inB` = 0, `alu_opc` = 0, `alu_inC` = 0.
- Request seen in IDLE at cycle T:
  - T+1: `ack` is high, `alu_*` carry the operands, `busy` = 1.
  - T+2: `done` is high, res/flags are valid, `busy` = 1.
  - T+3: IDLE, `busy` = 0; the earliest next grant is sampled in T+3.
- Latency from req to done is 2 cycles. Throughput is one operation per 3 cycles.
- ack and done are exactly one cycle wide. Only the granted requester sees them.
- Reset mid-operation (rst high in EXEC or RESP): the operation is dropped with no done; all outputs return to reset values on the next edge.
- rst has priority over all other inputs.

## Test plan
- **Reset:** hold rst for 2 cycles with `r0_req`=1 → no ack, all outputs 0, `busy`=0 on the cycle after reset.
- **Single requester 0:** req with a=FFFE, b=0003, c=0, opc=0.
  - Ack 1 cycle later, with `alu_inA`=FFFE and `alu_inB`=0003 in that cycle.
  - Done 2 cycles later; `r0_res`/`r0_zer`/`r0_neg` equal the `ALU1` output for those inputs.
  - r1 outputs stay 0.
- **Opcode sweep:** r1 issues opc 0..7 with a=FFFE, b=0003 → 8 dones, each result matching both `ALU1` and `minimal_ALU` for the same inputs, with each res held until the next done.
- **Tie and round-robin:** both request from reset, each holding req until its own ack.
  - Grants go r0 then r1.
  - Then, with both held high for 6 further grants: r0,r1,r0,r1,r0,r1, with acks spaced 3 cycles apart.
- **Reset mid-operation:** assert rst in the EXEC cycle of an r0 operation → no `r0_done`, `r0_res` = 0, the next request is served normally.
- **Random:** 200 random requests (random a/b/c/opc, random req toggling) checked against a scoreboard → every ack followed by exactly one done for the same id, with matching ALU reference values.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharer for one external combinational 16-bit ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP: ack in EXEC, done with held result in RESP.
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic [2:0]  r0_opc,
    input  logic [2:0]  r1_opc,
    input  logic [15:0] r0_a,
    input  logic [15:0] r1_a,
    input  logic [15:0] r0_b,
    input  logic [15:0] r1_b,
    input  logic        r0_c,
    input  logic        r1_c,
    output logic        r0_ack,
    output logic        r1_ack,
    output logic        r0_done,
    output logic        r1_done,
    output logic [15:0] r0_res,
    output logic [15:0] r1_res,
    output logic        r0_zer,
    output logic        r0_neg,
    output logic        r1_zer,
    output logic        r1_neg,
    output logic [15:0] alu_inA,
    output logic [15:0] alu_inB,
    output logic [2:0]  alu_opc,
    output logic        alu_inC,
    input  logic [15:0] alu_outW,
    input  logic        alu_zer,
    input  logic        alu_neg,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   gnt_id;
    logic   last_grant;
    logic   win_id;
    logic   any_req;

    assign any_req = r0_req | r1_req;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        win_id    = 1'b0;
        // On a tie the requester that did not win last time goes next.
        if (r0_req && r1_req) begin
            win_id = ~last_grant;
        end else begin
            win_id = r1_req;
        end
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id     <= 1'b0;
            last_grant <= 1'b1;
            alu_inA    <= '0;
            alu_inB    <= '0;
            alu_opc    <= '0;
            alu_inC    <= 1'b0;
            r0_res     <= '0;
            r0_zer     <= 1'b0;
            r0_neg     <= 1'b0;
            r1_res     <= '0;
            r1_zer     <= 1'b0;
            r1_neg     <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt_id     <= win_id;
                last_grant <= win_id;
                alu_inA    <= win_id ? r1_a   : r0_a;
                alu_inB    <= win_id ? r1_b   : r0_b;
                alu_opc    <= win_id ? r1_opc : r0_opc;
                alu_inC    <= win_id ? r1_c   : r0_c;
            end
            // Operands have been on the ALU for a full cycle, so its outputs are settled here.
            if (state == EXEC) begin
                if (gnt_id) begin
                    r1_res <= alu_outW;
                    r1_zer <= alu_zer;
                    r1_neg <= alu_neg;
                end else begin
                    r0_res <= alu_outW;
                    r0_zer <= alu_zer;
                    r0_neg <= alu_neg;
                end
            end
        end
    end

    assign r0_ack  = (state == EXEC) && !gnt_id;
    assign r1_ack  = (state == EXEC) &&  gnt_id;
    assign r0_done = (state == RESP) && !gnt_id;
    assign r1_done = (state == RESP) &&  gnt_id;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector and scoreboard bench for alu_share_arbiter with a behavioural ALU beside it.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r1_req;
    logic [2:0]  r0_opc, r1_opc;
    logic [15:0] r0_a, r1_a, r0_b, r1_b;
    logic        r0_c, r1_c;
    logic        r0_ack, r1_ack, r0_done, r1_done;
    logic [15:0] r0_res, r1_res;
    logic        r0_zer, r0_neg, r1_zer, r1_neg;
    logic [15:0] alu_inA, alu_inB, alu_outW;
    logic [2:0]  alu_opc;
    logic        alu_inC, alu_zer, alu_neg, busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    function automatic logic [15:0] alu_ref(input logic [2:0] opc, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        case (opc)
            3'd0:    return a + b + {15'd0, c};
            3'd1:    return a - b - {15'd0, c};
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    assign alu_outW = alu_ref(alu_opc, alu_inA, alu_inB, alu_inC);
    assign alu_zer  = (alu_outW == 16'd0);
    assign alu_neg  = alu_outW[15];

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_opc(r0_opc), .r1_opc(r1_opc),
        .r0_a(r0_a), .r1_a(r1_a), .r0_b(r0_b), .r1_b(r1_b),
        .r0_c(r0_c), .r1_c(r1_c),
        .r0_ack(r0_ack), .r1_ack(r1_ack), .r0_done(r0_done), .r1_done(r1_done),
        .r0_res(r0_res), .r1_res(r1_res),
        .r0_zer(r0_zer), .r0_neg(r0_neg), .r1_zer(r1_zer), .r1_neg(r1_neg),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_opc(alu_opc), .alu_inC(alu_inC),
        .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_op(input logic id, input logic [2:0] opc, input logic [15:0] a,
                          input logic [15:0] b, input logic c);
        if (id) begin r1_opc = opc; r1_a = a; r1_b = b; r1_c = c; end
        else    begin r0_opc = opc; r0_a = a; r0_b = b; r0_c = c; end
    endtask

    task automatic set_req(input logic id, input logic v);
        if (id) r1_req = v; else r0_req = v;
    endtask

    function automatic logic [17:0] result_of(input logic id);
        return id ? {r1_zer, r1_neg, r1_res} : {r0_zer, r0_neg, r0_res};
    endfunction

    // Issues one operation from IDLE (caller sits on a falling edge) and returns the done-cycle result.
    task automatic do_op(input logic id, input logic [2:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic c, output logic [17:0] got);
        int  lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        set_op(id, opc, a, b, c);
        set_req(id, 1'b1);
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = id ? r1_ack : r0_ack;
        end
        check("ack_seen", {31'd0, seen}, 32'd1);
        check("ack_latency", lat, 32'd1);
        check("ack_other", {31'd0, id ? r0_ack : r1_ack}, 32'd0);
        check("alu_drive", {alu_opc, alu_inC, alu_inA, alu_inB}, {opc, c, a, b});
        check("busy_exec", {31'd0, busy}, 32'd1);
        set_req(id, 1'b0);
        @(negedge clk);
        check("done_pulse", {30'd0, r1_done, r0_done}, id ? 32'd2 : 32'd1);
        check("busy_resp", {31'd0, busy}, 32'd1);
        got = result_of(id);
        @(negedge clk);
        check("done_width", {30'd0, r1_done, r0_done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("res_held", result_of(id), got);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        id;
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] res;
        logic        zer;
        logic        neg;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [17:0] got, prev[2];
        int          acks, dones, raised, order[8], when[8], n_gnt, cyc;
        logic [17:0] exp_r[2];
        logic        pend[2];

        vecs[0]  = '{1'b0, 3'd0, 16'hFFFE, 16'h0003, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 16'hFFFE, 16'h0003, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 16'hFFFE, 16'h0003, 1'b0, 16'hFFFB, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 3'd2, 16'hFFFE, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'd3, 16'hFFFE, 16'h0003, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 3'd4, 16'hFFFE, 16'h0003, 1'b0, 16'hFFFD, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 3'd5, 16'hFFFE, 16'h0003, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 3'd6, 16'hFFFE, 16'h0003, 1'b0, 16'hFFFC, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 3'd7, 16'hFFFE, 16'h0003, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 3'd1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'd0, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'd4, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 3'd3, 16'h8000, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b1};

        // Reset while r0 is requesting: nothing may be granted.
        r1_req = 1'b0;
        set_op(1'b0, 3'd5, 16'h1234, 16'h5678, 1'b1);
        set_op(1'b1, 3'd3, 16'h4321, 16'h8765, 1'b1);
        r0_req = 1'b1;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        rst    = 1'b0;
        r0_req = 1'b0;
        @(negedge clk);
        check("rst_ack_after", {30'd0, r1_ack, r0_ack}, 32'd0);
        check("rst_done_busy", {29'd0, r1_done, r0_done, busy}, 32'd0);
        check("rst_r0", {14'd0, result_of(1'b0)}, 32'd0);
        check("rst_r1", {14'd0, result_of(1'b1)}, 32'd0);
        check("rst_alu", {alu_opc, alu_inC, alu_inA[11:0]}, 32'd0);
        check("rst_alu_b", {alu_inA[15:12], alu_inB}, 32'd0);

        // Table of single operations, including the full opcode sweep on r1.
        prev[0] = '0;
        prev[1] = '0;
        foreach (vecs[i]) begin
            do_op(vecs[i].id, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].c, got);
            check($sformatf("vec%0d_result", i), {14'd0, got},
                  {14'd0, vecs[i].zer, vecs[i].neg, vecs[i].res});
            check($sformatf("vec%0d_other_untouched", i), {14'd0, result_of(!vecs[i].id)},
                  {14'd0, prev[!vecs[i].id]});
            prev[vecs[i].id] = got;
        end

        // Tie from reset: r0 then r1, then six alternating grants with both held high.
        apply_reset(2);
        set_op(1'b0, 3'd0, 16'h0010, 16'h0020, 1'b0);
        set_op(1'b1, 3'd2, 16'h00FF, 16'h0F0F, 1'b0);
        r0_req = 1'b1;
        r1_req = 1'b1;
        n_gnt  = 0;
        cyc    = 0;
        while (n_gnt < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (r0_ack || r1_ack) begin
                order[n_gnt] = r1_ack ? 1 : 0;
                when[n_gnt]  = cyc;
                n_gnt++;
                if (n_gnt == 1) r0_req = 1'b0;
                if (n_gnt == 2) r0_req = 1'b1;
                if (n_gnt == 8) begin r0_req = 1'b0; r1_req = 1'b0; end
            end
        end
        check("tie_grant_count", n_gnt, 32'd8);
        for (int k = 0; k < n_gnt; k++) begin
            check($sformatf("tie_order%0d", k), order[k], k % 2);
            if (k > 0) check($sformatf("tie_spacing%0d", k), when[k] - when[k-1], 32'd3);
        end
        repeat (2) @(negedge clk);

        // Reset in the EXEC cycle of an r0 operation drops it.
        set_op(1'b0, 3'd0, 16'h1234, 16'h1111, 1'b0);
        r0_req = 1'b1;
        @(negedge clk);
        check("midrst_ack", {31'd0, r0_ack}, 32'd1);
        rst    = 1'b1;
        r0_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_done", {30'd0, r1_done, r0_done}, 32'd0);
        check("midrst_r0_res", {14'd0, result_of(1'b0)}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_alu", {alu_inA, alu_inB}, 32'd0);
        @(negedge clk);
        check("midrst_no_late_done", {30'd0, r1_done, r0_done}, 32'd0);
        do_op(1'b0, 3'd0, 16'h1234, 16'h1111, 1'b0, got);
        check("midrst_next_op", {14'd0, got}, {14'd0, 1'b0, 1'b0, 16'h2345});

        // Random traffic against a per-requester scoreboard.
        acks    = 0;
        dones   = 0;
        raised  = 0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        cyc     = 0;
        while ((raised < 200 || r0_req || r1_req || pend[0] || pend[1]) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            for (int id = 0; id < 2; id++) begin
                logic ack, done, req;
                ack  = id ? r1_ack  : r0_ack;
                done = id ? r1_done : r0_done;
                req  = id ? r1_req  : r0_req;
                if (done) begin
                    check("rnd_done_expected", {31'd0, pend[id]}, 32'd1);
                    check("rnd_result", {14'd0, result_of(id[0])}, {14'd0, exp_r[id]});
                    pend[id] = 1'b0;
                    dones++;
                end
                if (ack) begin
                    logic [15:0] r;
                    check("rnd_ack_had_req", {31'd0, req}, 32'd1);
                    r = id ? alu_ref(r1_opc, r1_a, r1_b, r1_c) : alu_ref(r0_opc, r0_a, r0_b, r0_c);
                    exp_r[id] = {r == 16'd0, r[15], r};
                    pend[id]  = 1'b1;
                    acks++;
                    set_req(id[0], 1'b0);
                end else if (!req && !pend[id] && raised < 200 && $urandom_range(0, 2) == 0) begin
                    set_op(id[0], 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                           1'($urandom_range(0, 1)));
                    set_req(id[0], 1'b1);
                    raised++;
                end
            end
        end
        check("rnd_ack_count", acks, 32'd200);
        check("rnd_done_count", dones, 32'd200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
